// File: rtl/pair_triple_pattern_gen.sv
// Emits a 3-bit triple whose 2-of-3 majority equals the requested outcome, cycling round-robin per outcome.
// resp_val rises LATENCY edges after the accept edge; one request in flight, req_rdy low until the response handshakes.
module pair_triple_pattern_gen #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic             req_want,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_in0,
    output logic             resp_in1,
    output logic             resp_in2,
    output logic [CNT_W-1:0] served_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] TIMER_INIT = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         timer_q, timer_d;
    logic               want_q, want_d;
    logic [1:0]         idx1_q, idx1_d;
    logic [1:0]         idx0_q, idx0_d;
    logic [2:0]         trip_q, trip_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Triples as {in2,in1,in0}; want=1 rows have at least two ones, want=0 rows at most one.
    function automatic logic [2:0] pick(input logic want, input logic [1:0] idx);
        logic [2:0] t;
        case ({want, idx})
            3'b100:  t = 3'b011;
            3'b101:  t = 3'b101;
            3'b110:  t = 3'b110;
            3'b111:  t = 3'b111;
            3'b000:  t = 3'b000;
            3'b001:  t = 3'b001;
            3'b010:  t = 3'b010;
            default: t = 3'b100;
        endcase
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            want_q  <= 1'b0;
            idx1_q  <= '0;
            idx0_q  <= '0;
            trip_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            want_q  <= want_d;
            idx1_q  <= idx1_d;
            idx0_q  <= idx0_d;
            trip_q  <= trip_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        want_d  = want_q;
        idx1_d  = idx1_q;
        idx0_d  = idx0_q;
        trip_d  = trip_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_val) begin
                    want_d  = req_want;
                    timer_d = TIMER_INIT;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (timer_q == 4'd0) begin
                    trip_d  = pick(want_q, want_q ? idx1_q : idx0_q);
                    state_d = RESP;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    if (want_q) begin
                        idx1_d = idx1_q + 2'd1;
                    end else begin
                        idx0_d = idx0_q + 2'd1;
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    trip_d  = 3'b000;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_rdy      = (state_q == IDLE);
        resp_val     = (state_q == RESP);
        resp_in0     = trip_q[0];
        resp_in1     = trip_q[1];
        resp_in2     = trip_q[2];
        served_count = cnt_q;
    end

endmodule

// File: tb/tb_pair_triple_pattern_gen.sv
// Directed bench: a LATENCY=1/CNT_W=8 instance and a LATENCY=3/CNT_W=2 instance on one clock.
module tb_pair_triple_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       rst, req_val, req_want, resp_rdy;
    logic       req_rdy, resp_val, r0, r1, r2;
    logic [7:0] cnt;

    logic       b_rst, b_req_val, b_req_want, b_resp_rdy;
    logic       b_req_rdy, b_resp_val, b_r0, b_r1, b_r2;
    logic [1:0] b_cnt;

    pair_triple_pattern_gen #(.LATENCY(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_want(req_want),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_in0(r0), .resp_in1(r1), .resp_in2(r2),
        .served_count(cnt)
    );

    pair_triple_pattern_gen #(.LATENCY(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .req_val(b_req_val), .req_rdy(b_req_rdy), .req_want(b_req_want),
        .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_in0(b_r0), .resp_in1(b_r1), .resp_in2(b_r2),
        .served_count(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst = 1'b1;
        req_val = 1'b0;
        resp_rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Full transaction with an always-ready consumer; lat counts edges from accept edge to resp_val high.
    task automatic a_txn(input logic want, output logic [2:0] trip, output int lat);
        int guard;
        guard = 0;
        while (!req_rdy && guard < 40) begin
            tick();
            guard++;
        end
        req_val = 1'b1;
        req_want = want;
        resp_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        req_want = ~want;
        lat = 0;
        while (!resp_val && lat < 40) begin
            tick();
            lat++;
        end
        trip = {r2, r1, r0};
        tick();
    endtask

    task automatic b_txn(input logic want, output logic [2:0] trip, output int lat);
        int guard;
        guard = 0;
        while (!b_req_rdy && guard < 40) begin
            tick();
            guard++;
        end
        b_req_val = 1'b1;
        b_req_want = want;
        b_resp_rdy = 1'b1;
        tick();
        b_req_val = 1'b0;
        b_req_want = ~want;
        lat = 0;
        while (!b_resp_val && lat < 40) begin
            tick();
            lat++;
        end
        trip = {b_r2, b_r1, b_r0};
        tick();
    endtask

    task automatic test_reset();
        reset_a();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({req_rdy, resp_val, r2, r1, r0, cnt} !== {1'b1, 1'b0, 3'b000, 8'd0}) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got rdy=%b val=%b trip=%b cnt=%0d, expected rdy=1 val=0 trip=000 cnt=0",
                         i, req_rdy, resp_val, {r2, r1, r0}, cnt);
            end
            tick();
        end
    endtask

    task automatic test_want1_wrap();
        logic [2:0] exp_trip [5];
        logic [2:0] trip;
        int lat;
        exp_trip = '{3'b011, 3'b101, 3'b110, 3'b111, 3'b011};
        for (int i = 0; i < 5; i++) begin
            a_txn(1'b1, trip, lat);
            checks++;
            if (trip !== exp_trip[i]) begin
                errors++;
                $display("FAIL want1_trip[%0d]: got %b expected %b", i, trip, exp_trip[i]);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL want1_latency[%0d]: got %0d edges expected 1", i, lat);
            end
        end
        checks++;
        if (cnt !== 8'd5) begin
            errors++;
            $display("FAIL want1_count: got %0d expected 5", cnt);
        end
    endtask

    task automatic test_interleave();
        logic [2:0] trip;
        int lat;
        reset_a();
        a_txn(1'b0, trip, lat);
        checks++;
        if (trip !== 3'b000) begin
            errors++;
            $display("FAIL interleave_0a: got %b expected 000", trip);
        end
        a_txn(1'b1, trip, lat);
        checks++;
        if (trip !== 3'b011) begin
            errors++;
            $display("FAIL interleave_1: got %b expected 011", trip);
        end
        a_txn(1'b0, trip, lat);
        checks++;
        if (trip !== 3'b001) begin
            errors++;
            $display("FAIL interleave_0b: got %b expected 001", trip);
        end
    endtask

    // Continues from interleave: idx1=1, count=3, so a want=1 request yields 101.
    task automatic test_hold();
        req_val = 1'b1;
        req_want = 1'b1;
        resp_rdy = 1'b0;
        tick();
        req_want = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            req_val = i[0];
            req_want = ~i[0];
            checks++;
            if ({resp_val, req_rdy, r2, r1, r0, cnt} !== {1'b1, 1'b0, 3'b101, 8'd3}) begin
                errors++;
                $display("FAIL hold[%0d]: got val=%b rdy=%b trip=%b cnt=%0d, expected val=1 rdy=0 trip=101 cnt=3",
                         i, resp_val, req_rdy, {r2, r1, r0}, cnt);
            end
            tick();
        end
        req_val = 1'b0;
        resp_rdy = 1'b1;
        tick();
        checks++;
        if ({req_rdy, resp_val, r2, r1, r0, cnt} !== {1'b1, 1'b0, 3'b000, 8'd4}) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b val=%b trip=%b cnt=%0d, expected rdy=1 val=0 trip=000 cnt=4",
                     req_rdy, resp_val, {r2, r1, r0}, cnt);
        end
        tick();
        tick();
        checks++;
        if ({req_rdy, resp_val, cnt} !== {1'b1, 1'b0, 8'd4}) begin
            errors++;
            $display("FAIL hold_no_queue: got rdy=%b val=%b cnt=%0d, expected rdy=1 val=0 cnt=4",
                     req_rdy, resp_val, cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] trip;
        int lat;
        reset_a();
        a_txn(1'b1, trip, lat);
        req_val = 1'b1;
        req_want = 1'b1;
        resp_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({req_rdy, resp_val, r2, r1, r0, cnt} !== {1'b1, 1'b0, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL reset_in_calc: got rdy=%b val=%b trip=%b cnt=%0d, expected rdy=1 val=0 trip=000 cnt=0",
                     req_rdy, resp_val, {r2, r1, r0}, cnt);
        end
        a_txn(1'b1, trip, lat);
        checks++;
        if (trip !== 3'b011) begin
            errors++;
            $display("FAIL after_calc_reset: got %b expected 011", trip);
        end
        req_val = 1'b1;
        req_want = 1'b1;
        resp_rdy = 1'b0;
        tick();
        req_val = 1'b0;
        tick();
        checks++;
        if ({resp_val, r2, r1, r0} !== {1'b1, 3'b101}) begin
            errors++;
            $display("FAIL pre_resp_reset: got val=%b trip=%b expected val=1 trip=101", resp_val, {r2, r1, r0});
        end
        rst = 1'b1;
        resp_rdy = 1'b1;
        tick();
        rst = 1'b0;
        resp_rdy = 1'b0;
        checks++;
        if ({req_rdy, resp_val, r2, r1, r0, cnt} !== {1'b1, 1'b0, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL reset_in_resp: got rdy=%b val=%b trip=%b cnt=%0d, expected rdy=1 val=0 trip=000 cnt=0",
                     req_rdy, resp_val, {r2, r1, r0}, cnt);
        end
        a_txn(1'b1, trip, lat);
        checks++;
        if (trip !== 3'b011) begin
            errors++;
            $display("FAIL after_resp_reset: got %b expected 011", trip);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_trip [7];
        logic [1:0] exp_cnt [7];
        logic [2:0] trip;
        logic       maj;
        int lat;
        exp_trip = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010};
        exp_cnt  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        b_rst = 1'b1;
        b_req_val = 1'b0;
        b_resp_rdy = 1'b0;
        tick();
        b_rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            b_txn(1'b0, trip, lat);
            maj = (trip[0] & trip[1]) | (trip[0] & trip[2]) | (trip[1] & trip[2]);
            checks++;
            if (trip !== exp_trip[i] || maj !== 1'b0) begin
                errors++;
                $display("FAIL b2b_trip[%0d]: got %b (majority %b) expected %b (majority 0)", i, trip, maj, exp_trip[i]);
            end
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got %0d edges expected 3", i, lat);
            end
            checks++;
            if (b_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, b_cnt, exp_cnt[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_val = 1'b0;
        req_want = 1'b0;
        resp_rdy = 1'b0;
        b_rst = 1'b1;
        b_req_val = 1'b0;
        b_req_want = 1'b0;
        b_resp_rdy = 1'b0;
        tick();
        test_reset();
        test_want1_wrap();
        test_interleave();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
